tt_sweep_checker: RTL and testbench

Synthesizable sweep driver and checker for small combinational blocks with up to a few single-bit inputs and one single-bit result, such as the 3-input truth-table cell.
- On a start pulse it drives every input vector in ascending order onto the block under check.
- After a programmable settle time it samples the result and compares it with a captured expected truth table.
- It reports each mismatch, the mismatch count, and a pass/fail flag.

It sits beside the block under check, so the simulation bench's generator and checker pair can be reused on an FPGA board.

---
 rtl/tt_sweep_checker.sv | 141 ++++++++++++++
 tb/tb_tt_sweep_checker.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_checker.sv
// Sweep driver and checker for a small combinational block: walks every input vector
// in ascending order, samples the block's result after a settle time, and counts mismatches.
module tt_sweep_checker #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic [2**N_IN-1:0]   exp_table,
  output logic [N_IN-1:0]      vec_o,
  input  logic                 r_i,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 err_valid,
  output logic [N_IN-1:0]      err_vec,
  output logic                 err_got,
  output logic [N_IN:0]        err_cnt
);

  // state | meaning
  // IDLE  | waiting for start; outputs hold the last sweep's results
  // DRIVE | vec_o held on the checked block while the settle counter runs down
  // CHECK | one cycle: r_i sampled and compared with the captured table
  // DONE  | one cycle: done/pass reported, start ignored
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  localparam logic [3:0]      SETTLE_LOAD = 4'(SETTLE - 1);
  localparam logic [N_IN-1:0] VEC_LAST    = '1;

  state_t              state_q, state_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic [3:0]          settle_q, settle_d;
  logic [2**N_IN-1:0]  exp_q, exp_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                err_valid_q, err_valid_d;
  logic [N_IN-1:0]     err_vec_q, err_vec_d;
  logic                err_got_q, err_got_d;
  logic [N_IN:0]       err_cnt_q, err_cnt_d;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    settle_d    = settle_q;
    exp_d       = exp_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = 1'b0;
    err_valid_d = 1'b0;
    err_vec_d   = err_vec_q;
    err_got_d   = err_got_q;
    err_cnt_d   = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          exp_d     = exp_table;
          err_cnt_d = '0;
          vec_d     = '0;
          settle_d  = SETTLE_LOAD;
          busy_d    = 1'b1;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (settle_q == '0) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q - 4'd1;
        end
      end
      CHECK: begin
        if (r_i != exp_q[vec_q]) begin
          err_valid_d = 1'b1;
          err_vec_d   = vec_q;
          err_got_d   = r_i;
          err_cnt_d   = err_cnt_q + 1'b1;
        end
        // pass uses the updated count so a last-vector mismatch is included
        if (vec_q == VEC_LAST) begin
          done_d  = 1'b1;
          pass_d  = (err_cnt_d == '0);
          busy_d  = 1'b0;
          state_d = DONE;
        end else begin
          vec_d    = vec_q + 1'b1;
          settle_d = SETTLE_LOAD;
          state_d  = DRIVE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= IDLE;
      vec_q       <= '0;
      settle_q    <= '0;
      exp_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_vec_q   <= '0;
      err_got_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      settle_q    <= settle_d;
      exp_q       <= exp_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_valid_q <= err_valid_d;
      err_vec_q   <= err_vec_d;
      err_got_q   <= err_got_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign vec_o     = vec_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_valid = err_valid_q;
  assign err_vec   = err_vec_q;
  assign err_got   = err_got_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: two instances (settle 1 and 3) share stimulus and are
// checked every cycle against an elapsed-cycle arithmetic model, plus literal checks.
module tb_tt_sweep_checker;
  localparam int NV = 8;
  localparam int S0 = 1;
  localparam int S1 = 3;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic start = 1'b0;
  logic [7:0] exp_table = 8'h00;
  logic [1:0][7:0] tab = '0;

  logic [1:0][2:0] vec, evec;
  logic [1:0][3:0] ecnt;
  logic [1:0] r, busy, done, pass, ev, egot;

  assign r[0] = tab[0][vec[0]];
  assign r[1] = tab[1][vec[1]];

  tt_sweep_checker #(.N_IN(3), .SETTLE(S0)) u0 (
    .clk(clk), .aresetn(aresetn), .start(start), .exp_table(exp_table),
    .vec_o(vec[0]), .r_i(r[0]), .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .err_valid(ev[0]), .err_vec(evec[0]), .err_got(egot[0]), .err_cnt(ecnt[0]));

  tt_sweep_checker #(.N_IN(3), .SETTLE(S1)) u1 (
    .clk(clk), .aresetn(aresetn), .start(start), .exp_table(exp_table),
    .vec_o(vec[1]), .r_i(r[1]), .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .err_valid(ev[1]), .err_vec(evec[1]), .err_got(egot[1]), .err_cnt(ecnt[1]));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int e0 = 0;

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, want, $time);
    end
  endtask

  // Model: each instance is either idle or some number of cycles j into a sweep of
  // period p = settle+1; vector k is driven for j in [k*p, (k+1)*p) and judged at j=(k+1)*p.
  bit m_act[2] = '{0, 0};
  int m_j[2] = '{0, 0};
  int m_cnt[2] = '{0, 0};
  logic [1:0][7:0] m_exp = '0;
  logic [1:0][2:0] m_vec = '0, m_evec = '0;
  logic [1:0] m_busy = '0, m_done = '0, m_pass = '0, m_ev = '0, m_egot = '0;

  initial forever begin
    @(posedge clk or negedge aresetn);
    if (!aresetn) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_j[i] = 0; m_cnt[i] = 0; m_exp[i] = '0; m_vec[i] = '0;
        m_evec[i] = '0; m_busy[i] = 0; m_done[i] = 0; m_pass[i] = 0; m_ev[i] = 0; m_egot[i] = 0;
      end
    end else begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
        int p, len, k;
        p = (i == 0) ? S0 + 1 : S1 + 1;
        len = NV * p;
        m_ev[i] = 0; m_done[i] = 0; m_pass[i] = 0;
        if (!m_act[i]) begin
          if (start) begin
            m_act[i] = 1; m_j[i] = 0; m_cnt[i] = 0; m_exp[i] = exp_table;
            m_vec[i] = '0; m_busy[i] = 1;
          end
        end else if (m_j[i] == len) begin
          m_act[i] = 0;
        end else begin
          m_j[i]++;
          if (m_j[i] % p == 0) begin
            k = m_j[i] / p - 1;
            if (tab[i][k] != m_exp[i][k]) begin
              m_ev[i] = 1; m_evec[i] = 3'(k); m_egot[i] = tab[i][k]; m_cnt[i]++;
            end
          end
          if (m_j[i] == len) begin
            m_done[i] = 1; m_pass[i] = (m_cnt[i] == 0); m_busy[i] = 0;
          end else begin
            m_vec[i] = 3'(m_j[i] / p);
          end
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d.vec_o", i), int'(vec[i]), int'(m_vec[i]));
      chk($sformatf("u%0d.busy", i), int'(busy[i]), int'(m_busy[i]));
      chk($sformatf("u%0d.done", i), int'(done[i]), int'(m_done[i]));
      chk($sformatf("u%0d.pass", i), int'(pass[i]), int'(m_pass[i]));
      chk($sformatf("u%0d.err_valid", i), int'(ev[i]), int'(m_ev[i]));
      chk($sformatf("u%0d.err_vec", i), int'(evec[i]), int'(m_evec[i]));
      chk($sformatf("u%0d.err_got", i), int'(egot[i]), int'(m_egot[i]));
      chk($sformatf("u%0d.err_cnt", i), int'(ecnt[i]), m_cnt[i]);
    end
  end

  logic [3:0] q0[$];
  logic [3:0] q1[$];
  initial forever begin
    @(negedge clk);
    if (ev[0]) q0.push_back({evec[0], egot[0]});
    if (ev[1]) q1.push_back({evec[1], egot[1]});
  end

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 e0 = cyc;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget, output int n);
    bit found;
    found = 0;
    for (int t = 0; t < budget && !found; t++) begin
      @(posedge clk);
      #1;
      if (done[i]) found = 1;
    end
    n = cyc - e0;
    if (!found) chk($sformatf("u%0d.done_timeout", i), 0, 1);
  endtask

  int n;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset.vec_o", int'(vec[0]), 0);
    chk("reset.err_cnt", int'(ecnt[1]), 0);
    aresetn = 1'b1;
    repeat (2) @(negedge clk);

    // Correct block: r_i follows 8'h36 exactly
    exp_table = 8'h36; tab[0] = 8'h36; tab[1] = 8'h36;
    q0.delete();
    pulse_start();
    wait_done(0, 40, n);
    chk("good.done_latency", n, 16);
    chk("good.pass", int'(pass[0]), 1);
    chk("good.err_cnt", int'(ecnt[0]), 0);
    chk("good.err_pulses", q0.size(), 0);
    repeat (40) @(negedge clk);

    // Faulty block: a^b^c against expected 8'h36
    tab[0] = 8'h96; q0.delete();
    pulse_start();
    wait_done(0, 40, n);
    chk("bad.done_latency", n, 16);
    chk("bad.err_valid_at_done", int'(ev[0]), 1);
    chk("bad.err_vec_last", int'(evec[0]), 7);
    chk("bad.err_got_last", int'(egot[0]), 1);
    chk("bad.err_cnt", int'(ecnt[0]), 2);
    chk("bad.pass", int'(pass[0]), 0);
    @(negedge clk); #1;
    chk("bad.err_pulses", q0.size(), 2);
    if (q0.size() == 2) chk("bad.first_report", int'(q0[0]), 4'b101_0);
    repeat (40) @(negedge clk);

    // Settle of 3: constant-1 block
    exp_table = 8'hFF; tab[0] = 8'hFF; tab[1] = 8'hFF; q1.delete();
    pulse_start();
    wait_done(1, 60, n);
    chk("settle3.done_latency", n, 32);
    chk("settle3.pass", int'(pass[1]), 1);
    repeat (5) @(negedge clk);
    exp_table = 8'h00; q1.delete();
    pulse_start();
    wait_done(1, 60, n);
    chk("settle3.all_bad_pass", int'(pass[1]), 0);
    @(negedge clk); #1;
    chk("settle3.err_pulses", q1.size(), 8);
    chk("settle3.err_cnt", int'(ecnt[1]), 8);
    repeat (10) @(negedge clk);

    // Reset during the drive of vector 3 on the settle-1 instance
    exp_table = 8'h36; tab[0] = 8'h96; tab[1] = 8'h3C;
    pulse_start();
    while (cyc - e0 < 6) @(posedge clk);
    #3 aresetn = 1'b0;
    #1;
    chk("abort.vec_o", int'(vec[0]), 0);
    chk("abort.busy", int'(busy[0]), 0);
    chk("abort.err_cnt", int'(ecnt[0]), 0);
    @(negedge clk) aresetn = 1'b1;
    repeat (3) @(negedge clk);
    pulse_start();
    wait_done(0, 40, n);
    chk("after_abort.done_latency", n, 16);
    chk("after_abort.err_cnt", int'(ecnt[0]), 2);
    repeat (40) @(negedge clk);

    // Start and table changes mid-sweep are ignored; start in DONE ignored, one later accepted
    exp_table = 8'h36; tab[0] = 8'h96;
    pulse_start();
    repeat (3) @(negedge clk);
    start = 1'b1; exp_table = 8'hFF;
    @(negedge clk) start = 1'b0;
    exp_table = 8'h00;
    wait_done(0, 40, n);
    chk("iso.done_latency", n, 16);
    chk("iso.err_cnt", int'(ecnt[0]), 2);
    start = 1'b1;
    @(posedge clk); #1;
    chk("iso.start_in_done_busy", int'(busy[0]), 0);
    chk("iso.start_in_done_cnt", int'(ecnt[0]), 2);
    @(posedge clk); #1;
    chk("iso.start_after_done_busy", int'(busy[0]), 1);
    chk("iso.start_after_done_cnt", int'(ecnt[0]), 0);
    @(negedge clk) start = 1'b0;
    repeat (40) @(negedge clk);

    // Random traffic: starts, table changes, block changes and occasional resets
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      aresetn = ($urandom_range(0, 99) != 0);
      start = ($urandom_range(0, 7) == 0);
      exp_table = 8'($urandom);
      if ($urandom_range(0, 15) == 0) tab[0] = 8'($urandom);
      if ($urandom_range(0, 15) == 0) tab[1] = 8'($urandom);
    end
    @(negedge clk) start = 1'b0; aresetn = 1'b1;
    repeat (40) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
